// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request and RAM-port bundle shared by mem_arbiter and its users
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [1:0]  ramstate;
  logic [31:0] ramload;
  logic        ihit;
  logic        dhit;
  logic [31:0] iload;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        bus_err;

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises I-fetch and D-access requests onto one RAM port
// Data beats instruction; a bounded wait timer aborts requests to a dead RAM.
module mem_arbiter #(
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_IREAD  = 2'd0,
    K_DREAD  = 2'd1,
    K_DWRITE = 2'd2
  } kind_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  // Wait counter is 8 bits and saturates, so very large timeouts clamp at 255.
  localparam logic [7:0] WAIT_LIMIT = (TIMEOUT >= 256) ? 8'hFF :
                                      (TIMEOUT < 1)    ? 8'h00 : 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  kind_t       kind_q;
  kind_t       kind_sel;
  logic        latch;
  logic        finish;
  logic        abort;
  logic [31:0] addr_sel;
  logic [31:0] addr_q;
  logic [31:0] store_q;
  logic [7:0]  wait_cnt;
  logic [31:0] iload_q;
  logic [31:0] dload_q;
  logic        bus_err_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    kind_sel   = kind_q;
    addr_sel   = bus.daddr;
    latch      = 1'b0;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dWEN) begin
          kind_sel   = K_DWRITE;
          latch      = 1'b1;
          state_next = REQ;
        end else if (bus.dREN) begin
          kind_sel   = K_DREAD;
          latch      = 1'b1;
          state_next = REQ;
        end else if (bus.iREN) begin
          kind_sel   = K_IREAD;
          addr_sel   = bus.iaddr;
          latch      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        // A completing ACCESS wins over a timeout expiring in the same cycle.
        if (bus.ramstate == RS_ACCESS) begin
          finish     = 1'b1;
          state_next = RESP;
        end else if (bus.ramstate == RS_ERROR || wait_cnt >= WAIT_LIMIT) begin
          abort      = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      kind_q    <= K_IREAD;
      addr_q    <= 32'd0;
      store_q   <= 32'd0;
      wait_cnt  <= 8'd0;
      iload_q   <= 32'd0;
      dload_q   <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      if (latch) begin
        kind_q   <= kind_sel;
        addr_q   <= addr_sel & 32'hFFFF_FFFC;
        store_q  <= bus.dstore;
        wait_cnt <= 8'd0;
      end else if (state == REQ && !finish && !abort && wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (finish) begin
        if (kind_q == K_IREAD) begin
          iload_q <= bus.ramload;
        end else if (kind_q == K_DREAD) begin
          dload_q <= bus.ramload;
        end
      end

      if (abort) begin
        bus_err_q <= 1'b1;
        if (kind_q == K_IREAD) begin
          iload_q <= ERRWORD;
        end else if (kind_q == K_DREAD) begin
          dload_q <= ERRWORD;
        end
      end
    end
  end

  // Strobes and hits decode straight from state so an async reset kills them at once.
  assign bus.ramREN   = (state == REQ) && (kind_q != K_DWRITE);
  assign bus.ramWEN   = (state == REQ) && (kind_q == K_DWRITE);
  assign bus.ihit     = (state == RESP) && (kind_q == K_IREAD);
  assign bus.dhit     = (state == RESP) && (kind_q != K_IREAD);
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.bus_err  = bus_err_q;

endmodule
